// File: rtl/frame_palindrome_if.sv
// frame_palindrome_if: word stream in, palindrome verdict out, both valid/ready
interface frame_palindrome_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 16
);
  logic [DATA_WIDTH-1:0]          din;
  logic                           din_valid;
  logic                           din_last;
  logic                           din_ready;
  logic                           dout_valid;
  logic                           dout_ready;
  logic                           dout;
  logic [$clog2(MAX_LEN+1)-1:0]   dout_len;
  logic                           dout_overflow;
  modport master (
    output din, din_valid, din_last, dout_ready,
    input  din_ready, dout_valid, dout, dout_len, dout_overflow
  );
  modport slave (
    input  din, din_valid, din_last, dout_ready,
    output din_ready, dout_valid, dout, dout_len, dout_overflow
  );
endinterface

// File: rtl/frame_palindrome_checker.sv
// frame_palindrome_checker: buffers a frame of words and checks it reads the same both ways
module frame_palindrome_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 16
) (
  input logic               clk,
  input logic               reset,
  frame_palindrome_if.slave io
);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int PW = $clog2(MAX_LEN);
  typedef enum logic [1:0] {COLLECT, CHECK, DONE} state_t;
  state_t                state_q;
  logic [CW-1:0]         count_q;
  logic                  ovf_q, ovf_d;
  logic [PW-1:0]         lo_q, hi_q, wr_idx;
  logic                  din_ready_q, dout_valid_q, dout_q;
  logic                  beat, store;
  logic [DATA_WIDTH-1:0] mem [MAX_LEN];
  always_comb begin
    beat   = io.din_valid & din_ready_q;
    store  = beat & (count_q < CW'(MAX_LEN));
    ovf_d  = ovf_q | (beat & ~store);
    wr_idx = count_q[PW-1:0];
  end
  always_ff @(posedge clk)
    if (store) mem[wr_idx] <= io.din;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= COLLECT;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      lo_q         <= '0;
      hi_q         <= '0;
      din_ready_q  <= 1'b1;
      dout_valid_q <= 1'b0;
      dout_q       <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: if (beat) begin
          if (store) count_q <= count_q + CW'(1);
          ovf_q <= ovf_d;
          if (io.din_last) begin
            din_ready_q <= 1'b0;
            if (ovf_d) begin
              state_q      <= DONE;
              dout_q       <= 1'b0;
              dout_valid_q <= 1'b1;
            end else begin
              // the last word is stored at index count_q, so that is hi
              state_q <= CHECK;
              lo_q    <= '0;
              hi_q    <= wr_idx;
            end
          end
        end
        CHECK: begin
          if (lo_q >= hi_q || mem[lo_q] != mem[hi_q]) begin
            state_q      <= DONE;
            dout_q       <= lo_q >= hi_q;
            dout_valid_q <= 1'b1;
          end else begin
            lo_q <= lo_q + PW'(1);
            hi_q <= hi_q - PW'(1);
          end
        end
        DONE: if (io.dout_ready) begin
          state_q      <= COLLECT;
          dout_valid_q <= 1'b0;
          din_ready_q  <= 1'b1;
          dout_q       <= 1'b0;
          count_q      <= '0;
          ovf_q        <= 1'b0;
        end
        default: state_q <= COLLECT;
      endcase
    end
  end
  assign io.din_ready     = din_ready_q;
  assign io.dout_valid    = dout_valid_q;
  assign io.dout          = dout_q;
  assign io.dout_len      = count_q;
  assign io.dout_overflow = ovf_q;
endmodule

// File: tb/tb_frame_palindrome_checker.sv
// tb_frame_palindrome_checker: directed and random frames against a queue-based reference
module tb_frame_palindrome_checker;
  localparam int DW = 8;
  localparam int ML = 16;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  frame_palindrome_if #(.DATA_WIDTH(DW), .MAX_LEN(ML)) bus ();
  frame_palindrome_checker #(.DATA_WIDTH(DW), .MAX_LEN(ML)) dut (.clk(clk), .reset(reset), .io(bus));
  int n_pass = 0;
  int n_tot = 0;
  logic [DW-1:0] frm[$];
  bit e_pal, e_ovf;
  int e_len, e_lat;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got %0h expected %0h", tag, got, exp);
  endtask
  // reference: a frame is a palindrome iff word j equals word n-1-j for every pair
  task automatic model;
    int n;
    n = frm.size();
    e_ovf = n > ML;
    e_len = e_ovf ? ML : n;
    e_pal = !e_ovf;
    e_lat = e_ovf ? 1 : n / 2 + 2;
    if (!e_ovf)
      for (int j = 0; j < n / 2; j++)
        if (frm[j] != frm[n-1-j]) begin
          e_pal = 1'b0;
          e_lat = j + 2;
          break;
        end
  endtask
  task automatic send(input bit with_last);
    int w;
    for (int i = 0; i < frm.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.din_valid = 1'b0;
        tick;
      end
      bus.din       = frm[i];
      bus.din_valid = 1'b1;
      bus.din_last  = with_last && (i == frm.size() - 1);
      w = 0;
      while (!bus.din_ready && w < 50) begin
        tick;
        w++;
      end
      if (w == 50) chk("din_ready_timeout", 0, 1);
      tick;
    end
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;
  endtask
  task automatic result(input string tag, input int hold);
    int lat;
    model();
    lat = 1;
    while (!bus.dout_valid && lat < 40) begin
      tick;
      lat++;
    end
    chk({tag, "_latency"}, lat, e_lat);
    chk({tag, "_dout"}, bus.dout, e_pal);
    chk({tag, "_len"}, bus.dout_len, e_len);
    chk({tag, "_ovf"}, bus.dout_overflow, e_ovf);
    chk({tag, "_din_ready"}, bus.din_ready, 0);
    for (int h = 0; h < hold; h++) begin
      bus.din       = 8'hEE;
      bus.din_valid = 1'b1;
      bus.din_last  = 1'b1;
      tick;
      chk({tag, "_hold_valid"}, bus.dout_valid, 1);
      chk({tag, "_hold_dout"}, bus.dout, e_pal);
      chk({tag, "_hold_len"}, bus.dout_len, e_len);
      chk({tag, "_hold_din_ready"}, bus.din_ready, 0);
    end
    bus.din_valid  = 1'b0;
    bus.din_last   = 1'b0;
    bus.dout_ready = 1'b1;
    tick;
    bus.dout_ready = 1'b0;
    chk({tag, "_post_valid"}, bus.dout_valid, 0);
    chk({tag, "_post_din_ready"}, bus.din_ready, 1);
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_din_ready"}, bus.din_ready, 1);
    chk({tag, "_dout_valid"}, bus.dout_valid, 0);
    chk({tag, "_dout"}, bus.dout, 0);
    chk({tag, "_len"}, bus.dout_len, 0);
    chk({tag, "_ovf"}, bus.dout_overflow, 0);
  endtask
  task automatic pulse_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask
  initial begin
    int n, kind;
    reset          = 1'b1;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.din_last   = 1'b0;
    bus.dout_ready = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    check_reset("reset");
    frm = '{8'h11, 8'h22, 8'h33, 8'h22, 8'h11};
    send(1);
    result("pal5", 0);
    frm = '{8'h11, 8'h22, 8'h23, 8'h11};
    send(1);
    result("mis4", 0);
    frm = '{8'hA5};
    send(1);
    result("single", 0);
    frm = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 6, 5, 4, 3, 2, 1, 0};
    send(1);
    result("pal16", 0);
    frm.delete();
    for (int i = 0; i < 17; i++) frm.push_back(DW'(i));
    send(1);
    result("ovf17", 0);
    frm = '{8'h5, 8'h5};
    send(1);
    result("after_ovf", 0);
    frm = '{8'h3C, 8'h3C, 8'h3C};
    send(1);
    result("hold5", 5);
    frm = '{8'h1, 8'h2, 8'h3};
    send(0);
    pulse_reset();
    check_reset("rst_collect");
    frm = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 6, 5, 4, 3, 2, 1, 0};
    send(1);
    tick;
    pulse_reset();
    check_reset("rst_check");
    frm = '{8'h7};
    send(1);
    result("fresh", 0);
    for (int r = 0; r < 40; r++) begin
      frm.delete();
      kind = $urandom_range(0, 2);
      n = (kind == 2) ? $urandom_range(1, ML + 3) : $urandom_range(1, ML);
      for (int i = 0; i < n; i++) frm.push_back(DW'($urandom_range(0, 3)));
      if (kind != 2)
        for (int i = 0; i < n / 2; i++) frm[n-1-i] = frm[i];
      if (kind == 1 && n > 1) frm[$urandom_range(0, n / 2 - 1)] ^= 8'h80;
      send(1);
      result($sformatf("rnd%0d", r), $urandom_range(0, 2));
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
